// File: rtl/if_stage_if.sv
// Instruction memory bus between the fetch stage (master) and instruction memory (slave).
interface if_stage_if;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_gnt;
  logic        instr_rvalid;
  logic [31:0] instr_rdata;

  modport master (
    output instr_req,
    output instr_addr,
    input  instr_gnt,
    input  instr_rvalid,
    input  instr_rdata
  );

  modport slave (
    input  instr_req,
    input  instr_addr,
    output instr_gnt,
    output instr_rvalid,
    output instr_rdata
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: single-outstanding memory fetch, prefetch FIFO,
// IF/ID pipeline register and redirect handling.
//
// state | meaning
// IDLE  | prefetch FIFO full, no request outstanding
// REQ   | request raised, waiting for gnt
// WAIT  | request granted, waiting for rvalid
module if_stage #(
  parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  if_stage_if.master  instr_bus,
  input  logic [1:0]  pc_mux_i,
  input  logic [31:0] jal_addr_i,
  input  logic [31:0] branch_addr_i,
  input  logic        id_ready_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_rdata_o,
  output logic [31:0] pc_id_o
);
  localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH);
  localparam logic [31:0] BOOT_ALIGNED = {BOOT_ADDR[31:2], 2'b00};
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [1:0] PC_NEXT   = 2'd0;
  localparam logic [1:0] PC_JAL    = 2'd1;
  localparam logic [1:0] PC_BRANCH = 2'd2;
  localparam logic [1:0] PC_BOOT   = 2'd3;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

  state_e            state_q, state_d;
  logic [31:0]       fetch_addr_q, fetch_addr_d;
  logic [31:0]       req_pc_q, req_pc_d;
  logic              discard_q, discard_d;
  // lock_q: a redirect arrived while the request was still ungranted, so the
  // bus keeps presenting the old address (held in req_pc_q) until gnt.
  logic              lock_q, lock_d;

  logic [31:0]       fifo_instr_q [FIFO_DEPTH];
  logic [31:0]       fifo_pc_q    [FIFO_DEPTH];
  logic [PTR_W-1:0]  wptr_q, rptr_q;
  logic [PTR_W:0]    count_q, count_after;

  logic              redirect, granted, resp, push, pop, wr_en, rd_en;
  logic              fifo_empty, fifo_valid;
  logic [31:0]       target, head_instr, head_pc;

  assign redirect   = (pc_mux_i != PC_NEXT);
  assign instr_bus.instr_req  = (state_q == REQ);
  assign instr_bus.instr_addr = lock_q ? req_pc_q : fetch_addr_q;
  assign granted    = instr_bus.instr_req && instr_bus.instr_gnt;
  assign resp       = (state_q == WAIT) && instr_bus.instr_rvalid;
  assign push       = resp && !discard_q && !redirect;
  assign fifo_empty = (count_q == '0);
  assign fifo_valid = !fifo_empty || push;
  assign head_instr = fifo_empty ? instr_bus.instr_rdata : fifo_instr_q[rptr_q];
  assign head_pc    = fifo_empty ? req_pc_q : fifo_pc_q[rptr_q];
  assign pop        = id_ready_i && fifo_valid && !redirect;
  assign wr_en      = push && !(fifo_empty && pop);
  assign rd_en      = pop && !fifo_empty;
  assign count_after = count_q + {{PTR_W{1'b0}}, wr_en} - {{PTR_W{1'b0}}, rd_en};

  // Redirect target selection, always word aligned.
  always_comb begin
    target = fetch_addr_q;
    case (pc_mux_i)
      PC_JAL:    target = jal_addr_i;
      PC_BRANCH: target = branch_addr_i;
      PC_BOOT:   target = BOOT_ALIGNED;
      default:   target = fetch_addr_q;
    endcase
    target[1:0] = 2'b00;
  end

  // Fetch FSM next state and fetch/discard bookkeeping.
  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    req_pc_d     = req_pc_q;
    discard_d    = discard_q;
    lock_d       = lock_q;
    case (state_q)
      IDLE: begin
        if (redirect) begin
          fetch_addr_d = target;
          state_d      = REQ;
        end else if (count_q < DEPTH_CNT) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (granted) begin
          state_d = WAIT;
          lock_d  = 1'b0;
          if (redirect) begin
            fetch_addr_d = target;
            discard_d    = 1'b1;
          end else if (!lock_q) begin
            req_pc_d     = fetch_addr_q;
            fetch_addr_d = fetch_addr_q + 32'd4;
          end
        end else if (redirect) begin
          fetch_addr_d = target;
          discard_d    = 1'b1;
          if (!lock_q) begin
            req_pc_d = fetch_addr_q;
            lock_d   = 1'b1;
          end
        end
      end
      WAIT: begin
        if (instr_bus.instr_rvalid) begin
          discard_d = 1'b0;
          if (redirect) begin
            fetch_addr_d = target;
            state_d      = REQ;
          end else begin
            state_d = (count_after < DEPTH_CNT) ? REQ : IDLE;
          end
        end else if (redirect) begin
          fetch_addr_d = target;
          discard_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Fetch FSM and address registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      fetch_addr_q <= BOOT_ALIGNED;
      req_pc_q     <= BOOT_ALIGNED;
      discard_q    <= 1'b0;
      lock_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      req_pc_q     <= req_pc_d;
      discard_q    <= discard_d;
      lock_q       <= lock_d;
    end
  end

  // Prefetch FIFO pointers and occupancy; a redirect empties it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (redirect) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) wptr_q <= wptr_q + 1'b1;
      if (rd_en) rptr_q <= rptr_q + 1'b1;
      count_q <= count_after;
    end
  end

  // Prefetch FIFO storage; contents are only meaningful below count_q.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      fifo_instr_q[wptr_q] <= instr_bus.instr_rdata;
      fifo_pc_q[wptr_q]    <= req_pc_q;
    end
  end

  // IF/ID register: NOP bubble on redirect or empty FIFO, hold while decode stalls.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      instr_valid_o <= 1'b0;
      instr_rdata_o <= NOP_INSTR;
      pc_id_o       <= 32'h0;
    end else if (redirect) begin
      instr_valid_o <= 1'b0;
      instr_rdata_o <= NOP_INSTR;
    end else if (id_ready_i) begin
      if (fifo_valid) begin
        instr_valid_o <= 1'b1;
        instr_rdata_o <= head_instr;
        pc_id_o       <= head_pc;
      end else begin
        instr_valid_o <= 1'b0;
        instr_rdata_o <= NOP_INSTR;
      end
    end
  end
endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: memory responder, sequential-PC reference model,
// directed redirect scenarios and a randomized soak.
module tb_if_stage;
  localparam logic [31:0] BOOT = 32'h0000_0100;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [1:0]  pc_mux_i = 2'd0;
  logic [31:0] jal_addr_i = 32'h0;
  logic [31:0] branch_addr_i = 32'h0;
  logic        id_ready_i = 1'b1;
  logic        instr_valid_o;
  logic [31:0] instr_rdata_o;
  logic [31:0] pc_id_o;

  if_stage_if bus ();

  if_stage #(.BOOT_ADDR(BOOT), .FIFO_DEPTH(2), .NOP_INSTR(NOP)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .instr_bus     (bus),
    .pc_mux_i      (pc_mux_i),
    .jal_addr_i    (jal_addr_i),
    .branch_addr_i (branch_addr_i),
    .id_ready_i    (id_ready_i),
    .instr_valid_o (instr_valid_o),
    .instr_rdata_o (instr_rdata_o),
    .pc_id_o       (pc_id_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  // Reference model: next PC decode must see, plus memory responder state.
  logic [31:0] exp_pc = BOOT;
  int          consumed = 0;
  bit          rsp_pend = 0;
  logic [31:0] rsp_addr = 32'h0;
  int          rsp_wait = 0;
  int          gnt_mode = 1;   // 0 random, 1 always, 2 never
  int          lat_fix = 1;    // 0 random 1..3
  bit          stale_pulse = 0;
  logic [31:0] last_gnt = 32'h0;
  int          gnt_cnt = 0;
  bit          hold_req = 0;
  logic [31:0] hold_addr = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h3C5A_0F00;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive memory side, check the bus and decode side, advance.
  task automatic step();
    logic g;
    bit   inflight;
    inflight = rsp_pend;
    bus.instr_rvalid = 1'b0;
    bus.instr_rdata  = 32'h0;
    if (stale_pulse) begin
      bus.instr_rvalid = 1'b1;
      bus.instr_rdata  = mem_word(32'hDEAD_BEE0);
      stale_pulse = 0;
    end else if (rsp_pend) begin
      rsp_wait--;
      if (rsp_wait == 0) begin
        bus.instr_rvalid = 1'b1;
        bus.instr_rdata  = mem_word(rsp_addr);
        rsp_pend = 0;
      end
    end
    case (gnt_mode)
      1: g = 1'b1;
      2: g = 1'b0;
      default: g = ($urandom_range(1, 0) == 1);
    endcase
    bus.instr_gnt = bus.instr_req && g;
    #1;
    if (bus.instr_req) begin
      chk("one_outstanding", {31'b0, inflight}, 32'h0);
      chk("addr_align", bus.instr_addr & 32'h3, 32'h0);
    end
    if (hold_req) begin
      chk("req_held", {31'b0, bus.instr_req}, 32'h1);
      chk("addr_held", bus.instr_addr, hold_addr);
    end
    hold_req  = bus.instr_req && !bus.instr_gnt;
    hold_addr = bus.instr_addr;
    if (instr_valid_o && id_ready_i) begin
      chk("pc_seq", pc_id_o, exp_pc);
      chk("instr_data", instr_rdata_o, mem_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
      consumed++;
    end
    if (bus.instr_req && bus.instr_gnt) begin
      rsp_pend = 1;
      rsp_addr = bus.instr_addr;
      rsp_wait = (lat_fix != 0) ? lat_fix : int'($urandom_range(3, 1));
      last_gnt = bus.instr_addr;
      gnt_cnt++;
    end
    case (pc_mux_i)
      2'd1: exp_pc = jal_addr_i & ~32'h3;
      2'd2: exp_pc = branch_addr_i & ~32'h3;
      2'd3: exp_pc = BOOT & ~32'h3;
      default: ;
    endcase
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_gnt(input string tag, input int max_cyc);
    int start;
    bit got;
    start = gnt_cnt;
    got = 0;
    for (int i = 0; i < max_cyc && !got; i++) begin
      step();
      got = (gnt_cnt != start);
    end
    checks++;
    assert (got) else begin
      errors++;
      $error("FAIL %s: observed=no grant expected=grant within %0d cycles", tag, max_cyc);
    end
  endtask

  task automatic wait_valid(input string tag, input int max_cyc);
    bit got;
    got = instr_valid_o;
    for (int i = 0; i < max_cyc && !got; i++) begin
      step();
      got = instr_valid_o;
    end
    checks++;
    assert (got) else begin
      errors++;
      $error("FAIL %s: observed=no valid expected=valid within %0d cycles", tag, max_cyc);
    end
  endtask

  task automatic redirect(input logic [1:0] mux, input logic [31:0] addr);
    pc_mux_i = mux;
    jal_addr_i = addr;
    branch_addr_i = addr;
    step();
    pc_mux_i = 2'd0;
    chk("redir_valid", {31'b0, instr_valid_o}, 32'h0);
    chk("redir_nop", instr_rdata_o, NOP);
  endtask

  initial begin
    int c0;
    logic [31:0] old_addr;
    bus.instr_gnt = 1'b0;
    bus.instr_rvalid = 1'b0;
    bus.instr_rdata = 32'h0;

    // Reset values
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_req", {31'b0, bus.instr_req}, 32'h0);
    chk("rst_addr", bus.instr_addr, BOOT);
    chk("rst_valid", {31'b0, instr_valid_o}, 32'h0);
    chk("rst_rdata", instr_rdata_o, NOP);
    chk("rst_pc", pc_id_o, 32'h0);
    rst_ni = 1'b1;
    stale_pulse = 1;

    // Streaming from boot address, immediate gnt, rvalid one cycle later
    gnt_mode = 1; lat_fix = 1; id_ready_i = 1'b1;
    wait_gnt("first_gnt", 10);
    chk("first_addr", last_gnt, BOOT);
    wait_valid("first_valid", 10);
    chk("first_pc", pc_id_o, BOOT);
    c0 = consumed;
    repeat (20) step();
    chk("stream_rate", {31'b0, (consumed - c0) >= 8}, 32'h1);

    // Decode stall: FIFO fills, requests stop, then back-to-back delivery
    id_ready_i = 1'b0;
    repeat (6) step();
    chk("stall_req_drop", {31'b0, bus.instr_req}, 32'h0);
    id_ready_i = 1'b1;
    step();
    chk("release_valid0", {31'b0, instr_valid_o}, 32'h1);
    step();
    chk("release_valid1", {31'b0, instr_valid_o}, 32'h1);

    // JAL to unaligned target while waiting for a response
    lat_fix = 2;
    wait_gnt("jal_pre_gnt", 10);
    redirect(2'd1, 32'h0000_0203);
    wait_gnt("jal_gnt", 10);
    chk("jal_addr", last_gnt, 32'h0000_0200);
    wait_valid("jal_valid", 10);
    chk("jal_pc", pc_id_o, 32'h0000_0200);

    // Branch while request is up and gnt is withheld
    lat_fix = 1;
    gnt_mode = 2;
    for (int i = 0; i < 10 && !bus.instr_req; i++) step();
    chk("br_req_up", {31'b0, bus.instr_req}, 32'h1);
    old_addr = bus.instr_addr;
    redirect(2'd2, 32'h0000_3000);
    step();
    step();
    chk("br_addr_hold", bus.instr_addr, old_addr);
    gnt_mode = 1;
    wait_gnt("br_old_gnt", 10);
    chk("br_old_addr", last_gnt, old_addr);
    wait_gnt("br_new_gnt", 10);
    chk("br_new_addr", last_gnt, 32'h0000_3000);
    wait_valid("br_valid", 10);
    chk("br_pc", pc_id_o, 32'h0000_3000);

    // Redirect coinciding with rvalid while decode is stalled
    wait_gnt("rv_pre_gnt", 10);
    id_ready_i = 1'b0;
    redirect(2'd2, 32'h0000_4000);
    repeat (4) step();
    id_ready_i = 1'b1;
    wait_valid("rv_valid", 10);
    chk("rv_pc", pc_id_o, 32'h0000_4000);

    // Address wrap at top of memory
    redirect(2'd1, 32'hFFFF_FFFC);
    wait_gnt("wrap_gnt0", 10);
    chk("wrap_addr0", last_gnt, 32'hFFFF_FFFC);
    wait_gnt("wrap_gnt1", 10);
    chk("wrap_addr1", last_gnt, 32'h0000_0000);
    repeat (6) step();

    // Randomized soak with a reset in the middle
    gnt_mode = 0;
    lat_fix = 0;
    c0 = consumed;
    for (int n = 0; n < 1500; n++) begin
      if (n == 700) begin
        pc_mux_i = 2'd0;
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_req", {31'b0, bus.instr_req}, 32'h0);
        chk("mid_rst_valid", {31'b0, instr_valid_o}, 32'h0);
        chk("mid_rst_addr", bus.instr_addr, BOOT);
        rsp_pend = 0;
        hold_req = 0;
        exp_pc = BOOT;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        stale_pulse = 1;
      end
      id_ready_i = ($urandom_range(3, 0) != 0);
      if ($urandom_range(19, 0) == 0) begin
        pc_mux_i = 2'($urandom_range(3, 1));
        jal_addr_i = $urandom;
        branch_addr_i = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFF8 : $urandom;
      end else begin
        pc_mux_i = 2'd0;
      end
      step();
    end
    pc_mux_i = 2'd0;
    chk("soak_progress", {31'b0, (consumed - c0) > 50}, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
